// File: rtl/dsram_bus_bridge.sv
// Responder for the CPU data-SRAM port: replays each access onto a valid/ready memory bus,
// stalls the pipeline until the response is back, and holds load data for the MEM stage.
module dsram_bus_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                stallreq,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [DATA_W/8-1:0] mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata,
    output logic                timeout_err
);

    localparam int unsigned BeW = DATA_W / 8;
    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [BeW-1:0]    we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              timeout_hit;
    logic              abort;

    assign timeout_hit = (cnt_q == CntLast);

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        stallreq = 1'b0;
        abort    = 1'b0;

        unique case (state_q)
            StIdle: begin
                stallreq = data_sram_en;
                if (data_sram_en) begin
                    we_d    = data_sram_wen;
                    addr_d  = data_sram_addr;
                    wdata_d = data_sram_wdata;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = StReq;
                end
            end
            StReq: begin
                stallreq = 1'b1;
                cnt_d    = cnt_q + 8'd1;
                if (mem_req_ready) begin
                    valid_d = 1'b0;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            StResp: begin
                stallreq = 1'b1;
                cnt_d    = cnt_q + 8'd1;
                if (mem_resp_valid) begin
                    // Store acks carry no data; the last load result stays visible.
                    if (we_q == '0) begin
                        rdata_d = mem_resp_rdata;
                    end
                    state_d = StDone;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            StDone: begin
                // The completed request is still on the port here; it must not be reissued.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            state_d = StDone;
            if (we_q == '0) begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign mem_req_valid   = valid_q;
    assign mem_req_we      = we_q;
    assign mem_req_addr    = addr_q;
    assign mem_req_wdata   = wdata_q;
    assign timeout_err     = err_q;

endmodule

// File: tb/tb_dsram_bus_bridge.sv
// Bench for dsram_bus_bridge: a pipeline driver, a memory responder and a transaction-level
// model that predicts every output on every cycle.
module tb_dsram_bus_bridge;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        terr;

    always #5 clk = ~clk;

    dsram_bus_bridge #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_sram_en   (en),
        .data_sram_wen  (wen),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .stallreq       (stall),
        .mem_req_valid  (req_valid),
        .mem_req_ready  (req_ready),
        .mem_req_we     (req_we),
        .mem_req_addr   (req_addr),
        .mem_req_wdata  (req_wdata),
        .mem_resp_valid (resp_valid),
        .mem_resp_rdata (resp_rdata),
        .timeout_err    (terr)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External memory contents, shared by the responder and the load-data prediction.
    logic [31:0] mem [bit [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] t;
        t = mem_rd(a);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) t[8*b +: 8] = d[8*b +: 8];
        end
        mem[a] = t;
    endtask

    // Transaction-level model of what the bridge has promised.
    bit          m_pend, m_acc, m_done, m_err;
    logic [7:0]  m_age;
    logic [3:0]  m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_fin = 0;
    int          bus_hs = 0;
    int          stall_cnt = 0;

    // Responder state and knobs.
    bit          r_acc = 1'b0;
    int          r_rdy_wait = 0;
    int          r_rsp_wait = 0;
    logic [3:0]  r_we;
    logic [31:0] r_addr, r_wdata;
    int          cfg_rdy = 0;
    int          cfg_rsp = 1;
    bit          cfg_noresp = 1'b0;
    bit          spur_en = 1'b0;
    bit          force_resp = 1'b0;
    logic [31:0] force_data;

    // Pipeline driver state.
    typedef struct {
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;
    req_t q[$];
    bit   rand_mode = 1'b0;
    bit   rst_req = 1'b0;
    bit   prev_stall = 1'b0;

    function automatic int pick_rdy();
        return (cfg_rdy >= 0) ? cfg_rdy : int'($urandom_range(0, 3));
    endfunction

    function automatic int pick_rsp();
        return (cfg_rsp >= 1) ? cfg_rsp : int'($urandom_range(1, 4));
    endfunction

    task automatic push(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.we = we;
        r.a  = a;
        r.d  = d;
        q.push_back(r);
    endtask

    task automatic step();
        bit exp_valid, exp_stall;
        @(negedge clk);
        rst = rst_req;
        rst_req = 1'b0;

        // Pipeline holds its request while stalled.
        if (!prev_stall) begin
            if (q.size() > 0) begin
                req_t r;
                r = q.pop_front();
                en = 1'b1; wen = r.we; addr = r.a; wdata = r.d;
            end else if (rand_mode && $urandom_range(0, 3) != 0) begin
                en    = 1'b1;
                wen   = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                wdata = $urandom;
            end else begin
                en = 1'b0; wen = 4'($urandom); addr = $urandom; wdata = $urandom;
            end
        end

        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = $urandom;
        if (r_acc) begin
            if (r_rsp_wait <= 1) begin
                resp_valid = 1'b1;
                resp_rdata = (r_we == 4'd0) ? mem_rd(r_addr) : $urandom;
            end
        end else if (req_valid && r_rdy_wait == 0) begin
            req_ready = 1'b1;
        end
        if (!r_acc && spur_en && $urandom_range(0, 7) == 0) begin
            resp_valid = 1'b1;
            resp_rdata = $urandom;
        end
        if (force_resp) begin
            resp_valid = 1'b1;
            resp_rdata = force_data;
            force_resp = 1'b0;
        end

        #1;
        exp_valid = m_pend && !m_acc;
        exp_stall = m_done ? 1'b0 : (m_pend ? 1'b1 : en);
        chk("mem_req_valid", {31'd0, req_valid}, {31'd0, exp_valid});
        chk("stallreq", {31'd0, stall}, {31'd0, exp_stall});
        chk("mem_req_we", {28'd0, req_we}, {28'd0, m_we});
        chk("mem_req_addr", req_addr, m_addr);
        chk("mem_req_wdata", req_wdata, m_wdata);
        chk("data_sram_rdata", rdata, m_rdata);
        chk("timeout_err", {31'd0, terr}, {31'd0, m_err});
        if (stall) stall_cnt++;
        if (req_valid && req_ready) bus_hs++;

        // Model advance over the coming edge.
        if (rst) begin
            m_pend = 0; m_acc = 0; m_done = 0; m_err = 0;
            m_we = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_pend) begin
            if (en) begin
                m_pend = 1; m_acc = 0; m_age = 8'd0;
                m_we = wen; m_addr = addr; m_wdata = wdata;
            end
        end else if (!m_acc && req_ready) begin
            m_acc = 1;
            m_age = m_age + 8'd1;
        end else if (m_acc && resp_valid) begin
            if (m_we == 4'd0) m_rdata = mem_rd(m_addr);
            m_pend = 0; m_done = 1; m_fin++;
        end else if (m_age == 8'(TO - 1)) begin
            m_err = 1;
            if (m_we == 4'd0) m_rdata = '0;
            m_pend = 0; m_done = 1; m_fin++;
        end else begin
            m_age = m_age + 8'd1;
        end

        // Responder advance.
        if (rst) begin
            r_acc = 1'b0;
            r_rdy_wait = pick_rdy();
        end else if (r_acc) begin
            if (r_rsp_wait <= 1) begin
                if (r_we != 4'd0) mem_wr(r_addr, r_we, r_wdata);
                r_acc = 1'b0;
                r_rdy_wait = pick_rdy();
            end else begin
                r_rsp_wait--;
            end
        end else if (req_ready) begin
            r_we = req_we; r_addr = req_addr; r_wdata = req_wdata;
            r_rdy_wait = pick_rdy();
            if (!cfg_noresp) begin
                r_acc = 1'b1;
                r_rsp_wait = pick_rsp();
            end
        end else if (req_valid && r_rdy_wait > 0) begin
            r_rdy_wait--;
        end

        // A reset also flushes the pipeline, so nothing is held afterwards.
        prev_stall = rst ? 1'b0 : stall;
    endtask

    task automatic wait_fin(input int n, input int max, input string name);
        int tgt;
        int k;
        tgt = m_fin + n;
        k = 0;
        while (m_fin < tgt && k < max) begin
            step();
            k++;
        end
        n_chk++;
        if (m_fin < tgt) begin
            n_fail++;
            $display("FAIL %s: no completion within %0d cycles", name, max);
        end
    endtask

    initial begin
        int hs0;
        rst = 1'b1; en = 1'b0; wen = '0; addr = '0; wdata = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        m_pend = 0; m_acc = 0; m_done = 0; m_err = 0; m_age = '0;
        m_we = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        repeat (2) @(posedge clk);

        // Reset state.
        step();
        chk("reset rdata", rdata, 32'h0);
        chk("reset valid", {31'd0, req_valid}, 32'h0);
        chk("reset addr", req_addr, 32'h0);
        chk("reset stall", {31'd0, stall}, 32'h0);
        chk("reset err", {31'd0, terr}, 32'h0);

        // 1: immediate ready, response one cycle after accept.
        mem[32'h40] = 32'hDEADBEEF;
        cfg_rdy = 0; cfg_rsp = 1; r_rdy_wait = 0;
        hs0 = bus_hs; stall_cnt = 0;
        push(4'd0, 32'h40, 32'h0);
        wait_fin(1, 20, "t1 load");
        step();
        chk("t1 rdata", rdata, 32'hDEADBEEF);
        chk("t1 stall cycles", stall_cnt, 32'd3);
        chk("t1 handshakes", bus_hs - hs0, 32'd1);
        chk("t1 stall in done", {31'd0, stall}, 32'h0);

        // 2: store with delayed ready.
        cfg_rdy = 3; r_rdy_wait = 3;
        push(4'b0011, 32'h100, 32'h1234);
        wait_fin(1, 30, "t2 store");
        step();
        chk("t2 addr", req_addr, 32'h100);
        chk("t2 we", {28'd0, req_we}, 32'h3);
        chk("t2 wdata", req_wdata, 32'h1234);
        chk("t2 rdata kept", rdata, 32'hDEADBEEF);
        chk("t2 mem bytes", {16'd0, mem_rd(32'h100) & 32'hFFFF}, 32'h1234);

        // 3: back-to-back loads.
        cfg_rdy = 0; r_rdy_wait = 0;
        mem[32'h10] = 32'h1111_0010;
        mem[32'h14] = 32'h2222_0014;
        hs0 = bus_hs;
        push(4'd0, 32'h10, 32'h0);
        push(4'd0, 32'h14, 32'h0);
        wait_fin(1, 20, "t3 first");
        step();
        chk("t3 first rdata", rdata, 32'h1111_0010);
        wait_fin(1, 20, "t3 second");
        step();
        chk("t3 second rdata", rdata, 32'h2222_0014);
        chk("t3 handshakes", bus_hs - hs0, 32'd2);

        // 6: spurious response while idle.
        force_resp = 1'b1; force_data = 32'h0000FFFF;
        step();
        step();
        chk("t6 rdata kept", rdata, 32'h2222_0014);
        chk("t6 idle stall", {31'd0, stall}, 32'h0);
        chk("t6 idle valid", {31'd0, req_valid}, 32'h0);

        // Randomized traffic with random latencies and stray responses.
        cfg_rdy = -1; cfg_rsp = -1; r_rdy_wait = pick_rdy();
        rand_mode = 1'b1; spur_en = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0; spur_en = 1'b0;
        for (int k = 0; k < 50 && (m_pend || m_done || prev_stall); k++) step();
        step();

        // 4: request accepted but never answered.
        cfg_rdy = 0; cfg_rsp = 1; r_rdy_wait = 0; cfg_noresp = 1'b1;
        stall_cnt = 0;
        push(4'd0, 32'h20, 32'h0);
        wait_fin(1, 400, "t4 timeout");
        step();
        cfg_noresp = 1'b0;
        chk("t4 err", {31'd0, terr}, 32'h1);
        chk("t4 rdata", rdata, 32'h0);
        chk("t4 stall cycles", stall_cnt, 32'd256);
        mem[32'h24] = 32'hCAFE_0024;
        push(4'd0, 32'h24, 32'h0);
        wait_fin(1, 20, "t4 recovery");
        step();
        chk("t4 recovery rdata", rdata, 32'hCAFE_0024);

        // 5: reset while waiting for the response.
        cfg_rsp = 5;
        push(4'd0, 32'h28, 32'h0);
        for (int k = 0; k < 10 && !r_acc; k++) step();
        rst_req = 1'b1;
        step();
        force_resp = 1'b1; force_data = 32'h5555_5555;
        step();
        chk("t5 stall", {31'd0, stall}, 32'h0);
        chk("t5 valid", {31'd0, req_valid}, 32'h0);
        chk("t5 err cleared", {31'd0, terr}, 32'h0);
        step();
        chk("t5 rdata", rdata, 32'h0);

        cfg_rsp = 2;
        mem[32'h2C] = 32'h0BAD_F00D;
        push(4'd0, 32'h2C, 32'h0);
        wait_fin(1, 20, "final load");
        step();
        chk("final rdata", rdata, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
